ysyx_22041211_mem_arbiter: RTL and testbench
============================================

# ysyx_22041211_mem_arbiter

Two-master, one-slave memory arbiter for the single-cycle-issue NPC core. It shares the one data/instruction memory port between the IFU (read-only fetch) and the LSU (load/store). Each transaction is granted to one master, forwarded to memory, tracked until the response arrives, and the response is routed back to the owning master. It sits between the IFU/LSU and the SRAM model. It replaces direct SRAM instantiation inside the fetch and load/store units.

## Interface
Parameters:
- ADDR_LEN, 32, address width
- DATA_LEN, 32, data width
- TIMEOUT, 255, maximum cycles spent waiting for a memory response before an error response is returned (must be ≥1)

Ports:
- clk  input  1  single clock; all state updates on posedge
- rst  input  1  reset, synchronous and active-high
- ifu_req_valid  input  1  IFU fetch request
- ifu_req_ready  output  1  IFU request accepted this cycle
- ifu_req_addr  input  ADDR_LEN  fetch address
- ifu_resp_valid  output  1  one-cycle pulse: fetch data valid
- ifu_resp_data  output  DATA_LEN  fetched word
- ifu_resp_err  output  1  qualifies ifu_resp_valid: timeout
- lsu_req_valid  input  1  LSU request
- lsu_req_ready  output  1  LSU request accepted this cycle
- lsu_req_addr  input  ADDR_LEN  access address
- lsu_req_wen  input  1  1 = store, 0 = load
- lsu_req_wdata  input  DATA_LEN  store data
- lsu_req_mask  input  8  byte mask (MEM_MASK_8/16/32 encodings)
- lsu_resp_valid  output  1  one-cycle pulse: load data or store ack
- lsu_resp_data  output  DATA_LEN  load data; 0 for stores
- lsu_resp_err  output  1  qualifies lsu_resp_valid: timeout
- mem_req_valid  output  1  request to memory
- mem_req_ready  input  1  memory accepts request
- mem_addr / mem_wdata  output  ADDR_LEN / DATA_LEN  latched request
- mem_wen  output  1  latched write enable
- mem_mask  output  8  latched byte mask (IFU transactions use MEM_MASK_32)
- mem_resp_valid  input  1  memory response pulse
- mem_resp_data  input  DATA_LEN  memory read data

## Operation
- States: IDLE, REQ, WAIT.
- IDLE:
  - ready is asserted combinationally to the winning requester only.
  - Winner when only one master is valid: that master.
  - Winner when both are valid: the master not granted most recently (round-robin via the last_grant flag).
  - Handshake (valid & ready): addr, wen, wdata and mask are latched, owner and last_grant are updated, and the state goes to REQ.
  - IFU latch values: wen=0, mask=MEM_MASK_32, wdata=0.
- REQ:
  - mem_req_valid=1, driven from the latched fields; the fields are stable until the handshake.
  - On mem_req_ready: go to WAIT and clear the timeout counter.
- WAIT:
  - The counter increments each cycle.
  - On mem_resp_valid: pulse the owner's resp_valid and pass data through combinationally (stores: data=0, err=0); go to IDLE.
  - If the counter reaches TIMEOUT with no response: pulse resp_valid with err=1 and data=0 to the owner; go to IDLE.
- Both ready outputs are 0 outside IDLE; a new request is never accepted while a transaction is open.
- A mem_resp_valid seen in IDLE or REQ is ignored and dropped. This includes a late response after a timeout. The memory must not respond in the cycle it accepts a request.
- Unused response outputs are 0.

## Timing
- Reset values:
  - state=IDLE, last_grant=IFU, so the LSU wins the first tie.
  - All ready, resp_valid, resp_err and mem_req_valid outputs are 0.
  - mem_addr, mem_wdata, mem_wen and mem_mask are 0; the counter is 0.
- Reset mid-transaction aborts immediately with no response to the owner. The memory-side request is dropped.
- Minimum latency:
  - Cycle 0: request accepted.
  - Cycle 1: mem_req_valid=1; if mem_req_ready, go to WAIT.
  - Cycle 2: earliest response. Back-to-back acceptance is possible at cycle 3.
- Counter width is clog2(TIMEOUT+1). Timeout fires in the WAIT cycle where counter==TIMEOUT, so WAIT lasts at most TIMEOUT+1 cycles.
- A response arriving in the same cycle as counter==TIMEOUT is a normal response (err=0).
- A master holding valid while not granted must keep its request fields stable.

## Structure
- Shared define file ysyx_22041211_define.v holds:
  - state encodings (ARB_IDLE/ARB_REQ/ARB_WAIT)
  - owner encoding (ARB_OWNER_IFU=0, ARB_OWNER_LSU=1)
  - MEM_MASK_8/16/32, which already exist there
- One sub-module: ysyx_22041211_rr_arb2, a two-requester round-robin grant with a registered last_grant. It updates only on an accepted handshake.
- The datapath latch registers, the FSM and the timeout counter live in the top module.

## Test plan
- Single IFU read of 0x80000000, memory ready immediately, response 0xDEADBEEF at cycle 2 -> ifu_resp_valid pulse at cycle 2, data 0xDEADBEEF, err=0; lsu_resp_valid stays 0.
- LSU store to 0x80001000, wdata 0x12345678, mask MEM_MASK_16 -> mem_wen=1 and mem_mask=MEM_MASK_16 held through a 3-cycle mem_req_ready stall; lsu_resp_valid with data 0.
- Both valid continuously after reset for 4 transactions -> grants in order LSU, IFU, LSU, IFU.
- TIMEOUT=4, memory accepts but never responds -> owner resp_valid with err=1 and data 0 exactly 5 cycles after entering WAIT. A later mem_resp_valid in IDLE produces no output pulse.
- rst asserted during WAIT -> next cycle all outputs are 0 and state is IDLE. A response arriving afterwards is ignored. The next tie goes to the LSU.

Source files
------------

// File: rtl/ysyx_22041211_mem_arbiter_pkg.sv
// Shared encodings for the IFU/LSU memory arbiter: FSM states, owner ids, byte masks.
// Mask values match the encodings used by the LSU and the SRAM model.
package ysyx_22041211_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_REQ  = 2'd1,
        ARB_WAIT = 2'd2
    } arb_state_e;

    localparam logic ARB_OWNER_IFU = 1'b0;
    localparam logic ARB_OWNER_LSU = 1'b1;

    localparam logic [7:0] MEM_MASK_8  = 8'h01;
    localparam logic [7:0] MEM_MASK_16 = 8'h03;
    localparam logic [7:0] MEM_MASK_32 = 8'h0f;

    // LSU wins when it is the only requester, or on a tie when the IFU was served last.
    function automatic logic rr_pick_lsu(input logic req_ifu, input logic req_lsu,
                                         input logic last_grant);
        return req_lsu & (~req_ifu | (last_grant == ARB_OWNER_IFU));
    endfunction

endpackage

// File: rtl/ysyx_22041211_mem_arbiter_rr_arb2.sv
// Two-requester round-robin grant; combinational grant, registered last_grant.
// last_grant only moves on an accepted handshake, so a stalled winner keeps its grant.
module ysyx_22041211_rr_arb2
    import ysyx_22041211_mem_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req_ifu_i,
    input  logic req_lsu_i,
    input  logic accept_i,
    output logic gnt_ifu_o,
    output logic gnt_lsu_o
);

    logic last_grant_q;
    logic last_grant_d;

    assign gnt_lsu_o = rr_pick_lsu(req_ifu_i, req_lsu_i, last_grant_q);
    assign gnt_ifu_o = req_ifu_i & ~gnt_lsu_o;

    always_comb begin
        last_grant_d = last_grant_q;
        if (accept_i) begin
            last_grant_d = gnt_lsu_o ? ARB_OWNER_LSU : ARB_OWNER_IFU;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= ARB_OWNER_IFU;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/ysyx_22041211_mem_arbiter.sv
// Shares one memory port between IFU fetch and LSU load/store; one transaction in flight.
// Accept -> REQ next cycle -> response earliest one cycle later; readies low while a transaction is open.
module ysyx_22041211_mem_arbiter
    import ysyx_22041211_mem_arbiter_pkg::*;
#(
    parameter int ADDR_LEN = 32,
    parameter int DATA_LEN = 32,
    parameter int TIMEOUT  = 255
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_LEN-1:0] ifu_req_addr,
    output logic                ifu_resp_valid,
    output logic [DATA_LEN-1:0] ifu_resp_data,
    output logic                ifu_resp_err,

    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_LEN-1:0] lsu_req_addr,
    input  logic                lsu_req_wen,
    input  logic [DATA_LEN-1:0] lsu_req_wdata,
    input  logic [7:0]          lsu_req_mask,
    output logic                lsu_resp_valid,
    output logic [DATA_LEN-1:0] lsu_resp_data,
    output logic                lsu_resp_err,

    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_LEN-1:0] mem_addr,
    output logic [DATA_LEN-1:0] mem_wdata,
    output logic                mem_wen,
    output logic [7:0]          mem_mask,
    input  logic                mem_resp_valid,
    input  logic [DATA_LEN-1:0] mem_resp_data
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    arb_state_e          state_q;
    logic                owner_q;
    logic [ADDR_LEN-1:0] addr_q;
    logic [DATA_LEN-1:0] wdata_q;
    logic                wen_q;
    logic [7:0]          mask_q;
    logic [CNT_W-1:0]    cnt_q;

    logic gnt_ifu;
    logic gnt_lsu;
    logic is_idle;
    logic is_wait;
    logic ifu_hs;
    logic lsu_hs;
    logic accept;
    logic to_hit;
    logic resp_fire;
    logic resp_err;
    logic [DATA_LEN-1:0] resp_data;

    ysyx_22041211_rr_arb2 u_rr_arb2 (
        .clk       (clk),
        .rst       (rst),
        .req_ifu_i (ifu_req_valid),
        .req_lsu_i (lsu_req_valid),
        .accept_i  (accept),
        .gnt_ifu_o (gnt_ifu),
        .gnt_lsu_o (gnt_lsu)
    );

    assign is_idle = (state_q == ARB_IDLE);
    assign is_wait = (state_q == ARB_WAIT);

    assign ifu_req_ready = is_idle & gnt_ifu;
    assign lsu_req_ready = is_idle & gnt_lsu;
    assign ifu_hs        = ifu_req_valid & ifu_req_ready;
    assign lsu_hs        = lsu_req_valid & lsu_req_ready;
    assign accept        = ifu_hs | lsu_hs;

    // A real response in the final WAIT cycle takes priority over the timeout.
    assign to_hit    = is_wait & (cnt_q == CNT_W'(TIMEOUT));
    assign resp_fire = is_wait & (mem_resp_valid | to_hit);
    assign resp_err  = resp_fire & ~mem_resp_valid;
    assign resp_data = (is_wait & mem_resp_valid & ~wen_q) ? mem_resp_data : '0;

    assign ifu_resp_valid = resp_fire & (owner_q == ARB_OWNER_IFU);
    assign ifu_resp_err   = resp_err  & (owner_q == ARB_OWNER_IFU);
    assign ifu_resp_data  = (owner_q == ARB_OWNER_IFU) ? resp_data : '0;

    assign lsu_resp_valid = resp_fire & (owner_q == ARB_OWNER_LSU);
    assign lsu_resp_err   = resp_err  & (owner_q == ARB_OWNER_LSU);
    assign lsu_resp_data  = (owner_q == ARB_OWNER_LSU) ? resp_data : '0;

    assign mem_req_valid = (state_q == ARB_REQ);
    assign mem_addr      = addr_q;
    assign mem_wdata     = wdata_q;
    assign mem_wen       = wen_q;
    assign mem_mask      = mask_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            owner_q <= ARB_OWNER_IFU;
            addr_q  <= '0;
            wdata_q <= '0;
            wen_q   <= 1'b0;
            mask_q  <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (lsu_hs) begin
                        owner_q <= ARB_OWNER_LSU;
                        addr_q  <= lsu_req_addr;
                        wdata_q <= lsu_req_wdata;
                        wen_q   <= lsu_req_wen;
                        mask_q  <= lsu_req_mask;
                        state_q <= ARB_REQ;
                    end else if (ifu_hs) begin
                        owner_q <= ARB_OWNER_IFU;
                        addr_q  <= ifu_req_addr;
                        wdata_q <= '0;
                        wen_q   <= 1'b0;
                        mask_q  <= MEM_MASK_32;
                        state_q <= ARB_REQ;
                    end
                end
                ARB_REQ: begin
                    if (mem_req_ready) begin
                        cnt_q   <= '0;
                        state_q <= ARB_WAIT;
                    end
                end
                ARB_WAIT: begin
                    if (resp_fire) begin
                        state_q <= ARB_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22041211_mem_arbiter.sv
// Directed bench for the IFU/LSU memory arbiter, built with TIMEOUT=4.
module tb_ysyx_22041211_mem_arbiter;
    import ysyx_22041211_mem_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ifu_req_valid = 1'b0;
    logic        ifu_req_ready;
    logic [31:0] ifu_req_addr = '0;
    logic        ifu_resp_valid;
    logic [31:0] ifu_resp_data;
    logic        ifu_resp_err;
    logic        lsu_req_valid = 1'b0;
    logic        lsu_req_ready;
    logic [31:0] lsu_req_addr = '0;
    logic        lsu_req_wen = 1'b0;
    logic [31:0] lsu_req_wdata = '0;
    logic [7:0]  lsu_req_mask = '0;
    logic        lsu_resp_valid;
    logic [31:0] lsu_resp_data;
    logic        lsu_resp_err;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_wen;
    logic [7:0]  mem_mask;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_resp_data = '0;

    int checks = 0;
    int errors = 0;

    ysyx_22041211_mem_arbiter #(.ADDR_LEN(32), .DATA_LEN(32), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_resp_data(ifu_resp_data), .ifu_resp_err(ifu_resp_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
        .lsu_req_wen(lsu_req_wen), .lsu_req_wdata(lsu_req_wdata), .lsu_req_mask(lsu_req_mask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_resp_data(lsu_resp_data), .lsu_resp_err(lsu_resp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wen(mem_wen), .mem_mask(mem_mask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
    );

    always #5 clk = ~clk;

    // Inputs change on the falling edge; outputs are sampled 1ns later, well away from posedge.
    task automatic next_cyc();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        next_cyc();
        next_cyc();
        #1;
        checks++; if (ifu_req_ready !== 1'b0 || lsu_req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got ifu=%b lsu=%b exp 0 0", ifu_req_ready, lsu_req_ready); end
        checks++; if (ifu_resp_valid !== 1'b0 || lsu_resp_valid !== 1'b0 || ifu_resp_err !== 1'b0 || lsu_resp_err !== 1'b0) begin errors++; $display("FAIL reset_resp got %b%b%b%b exp 0000", ifu_resp_valid, lsu_resp_valid, ifu_resp_err, lsu_resp_err); end
        checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_mem_req_valid got %b exp 0", mem_req_valid); end
        checks++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_wen !== 1'b0 || mem_mask !== 8'h0) begin errors++; $display("FAIL reset_mem_fields got %h %h %b %h exp all 0", mem_addr, mem_wdata, mem_wen, mem_mask); end
        rst = 1'b0;
        next_cyc();
    endtask

    // Both masters hold valid from reset onwards; grants must alternate starting with the LSU.
    task automatic test_round_robin();
        logic exp_lsu [4];
        exp_lsu[0] = 1'b1; exp_lsu[1] = 1'b0; exp_lsu[2] = 1'b1; exp_lsu[3] = 1'b0;
        ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0010;
        lsu_req_valid = 1'b1; lsu_req_addr = 32'h8000_2000; lsu_req_wen = 1'b0;
        lsu_req_wdata = 32'h0; lsu_req_mask = MEM_MASK_8;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (lsu_req_ready !== exp_lsu[i] || ifu_req_ready !== !exp_lsu[i]) begin errors++; $display("FAIL rr_grant[%0d] got lsu=%b ifu=%b exp lsu=%b", i, lsu_req_ready, ifu_req_ready, exp_lsu[i]); end
            next_cyc();
            mem_req_ready = 1'b1;
            #1;
            checks++; if (mem_req_valid !== 1'b1 || mem_addr !== (exp_lsu[i] ? 32'h8000_2000 : 32'h8000_0010)) begin errors++; $display("FAIL rr_mem_addr[%0d] got vld=%b addr=%h", i, mem_req_valid, mem_addr); end
            checks++; if (mem_mask !== (exp_lsu[i] ? MEM_MASK_8 : MEM_MASK_32)) begin errors++; $display("FAIL rr_mem_mask[%0d] got %h", i, mem_mask); end
            next_cyc();
            mem_req_ready = 1'b0;
            mem_resp_valid = 1'b1; mem_resp_data = 32'h1000 + i;
            #1;
            checks++; if (lsu_resp_valid !== exp_lsu[i] || ifu_resp_valid !== !exp_lsu[i]) begin errors++; $display("FAIL rr_resp_route[%0d] got lsu=%b ifu=%b exp lsu=%b", i, lsu_resp_valid, ifu_resp_valid, exp_lsu[i]); end
            checks++; if ((exp_lsu[i] ? lsu_resp_data : ifu_resp_data) !== 32'h1000 + i) begin errors++; $display("FAIL rr_resp_data[%0d] got lsu=%h ifu=%h exp %h", i, lsu_resp_data, ifu_resp_data, 32'h1000 + i); end
            next_cyc();
            mem_resp_valid = 1'b0;
        end
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        next_cyc();
    endtask

    task automatic test_ifu_read();
        ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0000;
        #1;
        checks++; if (ifu_req_ready !== 1'b1 || lsu_req_ready !== 1'b0 || mem_req_valid !== 1'b0) begin errors++; $display("FAIL ifu_accept got rdy=%b lsu_rdy=%b mvld=%b exp 1 0 0", ifu_req_ready, lsu_req_ready, mem_req_valid); end
        next_cyc();
        ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
        #1;
        checks++; if (mem_req_valid !== 1'b1 || mem_addr !== 32'h8000_0000 || mem_wen !== 1'b0 || mem_mask !== MEM_MASK_32 || mem_wdata !== 32'h0) begin errors++; $display("FAIL ifu_mem_req got vld=%b addr=%h wen=%b mask=%h wd=%h", mem_req_valid, mem_addr, mem_wen, mem_mask, mem_wdata); end
        checks++; if (ifu_req_ready !== 1'b0) begin errors++; $display("FAIL ifu_ready_busy got %b exp 0", ifu_req_ready); end
        next_cyc();
        mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 32'hDEAD_BEEF;
        #1;
        checks++; if (ifu_resp_valid !== 1'b1 || ifu_resp_data !== 32'hDEAD_BEEF || ifu_resp_err !== 1'b0) begin errors++; $display("FAIL ifu_resp got vld=%b data=%h err=%b exp 1 deadbeef 0", ifu_resp_valid, ifu_resp_data, ifu_resp_err); end
        checks++; if (lsu_resp_valid !== 1'b0 || lsu_resp_data !== 32'h0) begin errors++; $display("FAIL ifu_resp_lsu_quiet got vld=%b data=%h exp 0 0", lsu_resp_valid, lsu_resp_data); end
        next_cyc();
        mem_resp_valid = 1'b0;
        #1;
        checks++; if (ifu_resp_valid !== 1'b0 || ifu_resp_data !== 32'h0) begin errors++; $display("FAIL ifu_resp_pulse got vld=%b data=%h exp 0 0", ifu_resp_valid, ifu_resp_data); end
    endtask

    task automatic test_lsu_store();
        lsu_req_valid = 1'b1; lsu_req_addr = 32'h8000_1000; lsu_req_wen = 1'b1;
        lsu_req_wdata = 32'h1234_5678; lsu_req_mask = MEM_MASK_16;
        #1;
        checks++; if (lsu_req_ready !== 1'b1) begin errors++; $display("FAIL st_accept got %b exp 1", lsu_req_ready); end
        next_cyc();
        lsu_req_valid = 1'b0; lsu_req_wdata = 32'hFFFF_FFFF; lsu_req_mask = MEM_MASK_8; lsu_req_wen = 1'b0;
        for (int s = 0; s < 4; s++) begin
            mem_req_ready = (s == 3);
            #1;
            checks++; if (mem_req_valid !== 1'b1 || mem_wen !== 1'b1 || mem_mask !== MEM_MASK_16 || mem_addr !== 32'h8000_1000 || mem_wdata !== 32'h1234_5678) begin errors++; $display("FAIL st_hold[%0d] got vld=%b wen=%b mask=%h addr=%h wd=%h", s, mem_req_valid, mem_wen, mem_mask, mem_addr, mem_wdata); end
            next_cyc();
        end
        mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 32'hCAFE_F00D;
        #1;
        checks++; if (lsu_resp_valid !== 1'b1 || lsu_resp_data !== 32'h0 || lsu_resp_err !== 1'b0) begin errors++; $display("FAIL st_resp got vld=%b data=%h err=%b exp 1 0 0", lsu_resp_valid, lsu_resp_data, lsu_resp_err); end
        checks++; if (ifu_resp_valid !== 1'b0) begin errors++; $display("FAIL st_ifu_quiet got %b exp 0", ifu_resp_valid); end
        next_cyc();
        mem_resp_valid = 1'b0;
        #1;
        checks++; if (lsu_resp_valid !== 1'b0) begin errors++; $display("FAIL st_resp_pulse got %b exp 0", lsu_resp_valid); end
    endtask

    // TIMEOUT=4: WAIT counts 0..4 and the error fires on the fifth WAIT cycle.
    task automatic test_timeout();
        ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0040;
        #1;
        checks++; if (ifu_req_ready !== 1'b1) begin errors++; $display("FAIL to_accept got %b exp 1", ifu_req_ready); end
        next_cyc();
        ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
        for (int w = 0; w < 5; w++) begin
            next_cyc();
            mem_req_ready = 1'b0;
            #1;
            if (w < 4) begin
                checks++; if (ifu_resp_valid !== 1'b0) begin errors++; $display("FAIL to_early[%0d] got %b exp 0", w, ifu_resp_valid); end
            end else begin
                checks++; if (ifu_resp_valid !== 1'b1 || ifu_resp_err !== 1'b1 || ifu_resp_data !== 32'h0) begin errors++; $display("FAIL to_fire got vld=%b err=%b data=%h exp 1 1 0", ifu_resp_valid, ifu_resp_err, ifu_resp_data); end
                checks++; if (lsu_resp_valid !== 1'b0 || lsu_resp_err !== 1'b0) begin errors++; $display("FAIL to_lsu_quiet got %b %b exp 0 0", lsu_resp_valid, lsu_resp_err); end
            end
        end
        next_cyc();
        mem_resp_valid = 1'b1; mem_resp_data = 32'h55;
        #1;
        checks++; if (ifu_resp_valid !== 1'b0 || ifu_resp_err !== 1'b0 || lsu_resp_valid !== 1'b0) begin errors++; $display("FAIL to_late_resp got ifu=%b err=%b lsu=%b exp 0 0 0", ifu_resp_valid, ifu_resp_err, lsu_resp_valid); end
        next_cyc();
        mem_resp_valid = 1'b0;
    endtask

    task automatic test_timeout_boundary();
        lsu_req_valid = 1'b1; lsu_req_addr = 32'h8000_0080; lsu_req_wen = 1'b0; lsu_req_mask = MEM_MASK_32;
        next_cyc();
        lsu_req_valid = 1'b0; mem_req_ready = 1'b1;
        for (int w = 0; w < 5; w++) begin
            next_cyc();
            mem_req_ready = 1'b0;
            mem_resp_valid = (w == 4); mem_resp_data = 32'hA5A5_A5A5;
            #1;
            if (w < 4) begin
                checks++; if (lsu_resp_valid !== 1'b0) begin errors++; $display("FAIL edge_early[%0d] got %b exp 0", w, lsu_resp_valid); end
            end else begin
                checks++; if (lsu_resp_valid !== 1'b1 || lsu_resp_err !== 1'b0 || lsu_resp_data !== 32'hA5A5_A5A5) begin errors++; $display("FAIL edge_resp got vld=%b err=%b data=%h exp 1 0 a5a5a5a5", lsu_resp_valid, lsu_resp_err, lsu_resp_data); end
            end
        end
        next_cyc();
        mem_resp_valid = 1'b0;
    endtask

    // Abort an LSU transaction so last_grant would be LSU without reset; the next tie must still go to LSU.
    task automatic test_reset_in_wait();
        lsu_req_valid = 1'b1; lsu_req_addr = 32'h8000_0100; lsu_req_wen = 1'b0; lsu_req_mask = MEM_MASK_32;
        next_cyc();
        lsu_req_valid = 1'b0; mem_req_ready = 1'b1;
        next_cyc();
        mem_req_ready = 1'b0; rst = 1'b1;
        next_cyc();
        rst = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 32'h77;
        #1;
        checks++; if (lsu_resp_valid !== 1'b0 || ifu_resp_valid !== 1'b0 || lsu_resp_err !== 1'b0 || lsu_resp_data !== 32'h0) begin errors++; $display("FAIL rstw_resp got lsu=%b ifu=%b err=%b data=%h exp 0", lsu_resp_valid, ifu_resp_valid, lsu_resp_err, lsu_resp_data); end
        checks++; if (mem_req_valid !== 1'b0 || mem_addr !== 32'h0 || mem_mask !== 8'h0 || mem_wen !== 1'b0) begin errors++; $display("FAIL rstw_mem got vld=%b addr=%h mask=%h wen=%b exp 0", mem_req_valid, mem_addr, mem_mask, mem_wen); end
        next_cyc();
        mem_resp_valid = 1'b0;
        ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0300;
        lsu_req_valid = 1'b1; lsu_req_addr = 32'h8000_0200;
        #1;
        checks++; if (lsu_req_ready !== 1'b1 || ifu_req_ready !== 1'b0) begin errors++; $display("FAIL rstw_tie got lsu=%b ifu=%b exp 1 0", lsu_req_ready, ifu_req_ready); end
        next_cyc();
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        #1;
        checks++; if (mem_req_valid !== 1'b1 || mem_addr !== 32'h8000_0200) begin errors++; $display("FAIL rstw_next_req got vld=%b addr=%h exp 1 80000200", mem_req_valid, mem_addr); end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_ifu_read();
        test_lsu_store();
        test_timeout();
        test_timeout_boundary();
        test_reset_in_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
